// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control unit and the multiply/divide engine.
// The control unit drives the request side; the engine returns status and the HI/LO values.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic [1:0]       hilo_we;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, hilo_we,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, hilo_we,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed/unsigned multiply and restoring divide feeding HI/LO.
// Works on magnitudes one bit per cycle and applies the result signs in the final state.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_sh;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_zero;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;

    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shifted;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_dz_nxt;
    logic               w_wr_res;

    assign w_is_div   = r_op[1];
    assign w_a_neg    = ~r_op[0] & r_a[WIDTH-1];
    assign w_b_neg    = ~r_op[0] & r_b[WIDTH-1];
    assign w_a_abs    = w_a_neg ? -r_a : r_a;
    assign w_b_abs    = w_b_neg ? -r_b : r_b;
    assign w_sum      = {1'b0, r_acc} + {1'b0, (r_sh[0] ? r_opnd : {WIDTH{1'b0}})};
    assign w_shifted  = {r_acc, r_sh[WIDTH-1]};
    // Partial remainder is always below the divisor, so a WIDTH-bit difference is exact when w_ge.
    assign w_ge       = (w_shifted >= {1'b0, r_opnd});
    assign w_diff     = w_shifted[WIDTH-1:0] - r_opnd;
    assign w_prod     = {r_acc, r_sh};
    assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; flush aborts any in-flight state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.flush) w_next = S_PREP;
                else                         w_next = S_IDLE;
            end
            S_PREP: begin
                if (bus.flush)                                w_next = S_IDLE;
                else if (w_is_div && (r_b == {WIDTH{1'b0}}))  w_next = S_FIX;
                else                                          w_next = S_CALC;
            end
            S_CALC: begin
                if (bus.flush)                           w_next = S_IDLE;
                else if (r_cnt == CNT_W'(WIDTH - 1))     w_next = S_FIX;
                else                                     w_next = S_CALC;
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode for the registered status flags and the result write.
    always_comb begin
        w_busy_nxt = (w_next != S_IDLE);
        if (r_state == S_FIX && !bus.flush) begin
            w_done_nxt = 1'b1;
            w_dz_nxt   = r_zero;
            w_wr_res   = ~r_zero;
        end else begin
            w_done_nxt = 1'b0;
            w_dz_nxt   = 1'b0;
            w_wr_res   = 1'b0;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_div_zero <= w_dz_nxt;
        end
    end

    // Operand capture, iteration datapath and HI/LO update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_op     <= 2'b00;
            r_opnd   <= {WIDTH{1'b0}};
            r_acc    <= {WIDTH{1'b0}};
            r_sh     <= {WIDTH{1'b0}};
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_zero   <= 1'b0;
            r_cnt    <= {CNT_W{1'b0}};
            r_hi     <= {WIDTH{1'b0}};
            r_lo     <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.hilo_we[1]) r_hi <= bus.a;
                    if (bus.hilo_we[0]) r_lo <= bus.a;
                    if (bus.start && !bus.flush) begin
                        r_a  <= bus.a;
                        r_b  <= bus.b;
                        r_op <= bus.op;
                    end
                end
                S_PREP: begin
                    r_acc    <= {WIDTH{1'b0}};
                    r_cnt    <= {CNT_W{1'b0}};
                    r_zero   <= w_is_div && (r_b == {WIDTH{1'b0}});
                    r_neg_lo <= w_a_neg ^ w_b_neg;
                    r_neg_hi <= w_a_neg;
                    r_sh     <= w_is_div ? w_a_abs : w_b_abs;
                    r_opnd   <= w_is_div ? w_b_abs : w_a_abs;
                end
                S_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (!w_is_div) begin
                        r_acc <= w_sum[WIDTH:1];
                        r_sh  <= {w_sum[0], r_sh[WIDTH-1:1]};
                    end else if (w_ge) begin
                        r_acc <= w_diff;
                        r_sh  <= {r_sh[WIDTH-2:0], 1'b1};
                    end else begin
                        r_acc <= w_shifted[WIDTH-1:0];
                        r_sh  <= {r_sh[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    if (w_wr_res && !w_is_div) begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else if (w_wr_res) begin
                        r_hi <= r_neg_hi ? -r_acc : r_acc;
                        r_lo <= r_neg_lo ? -r_sh : r_sh;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, results, div-by-zero, flush and reset.
module tb_mult_div_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busy_cnt);
        busy_cnt = 0;
        cyc      = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        int bc;
        do_start(op, a, b);
        wait_done(cyc, bc);
        n_checks++;
        if (cyc !== 34) begin n_fail++; $display("FAIL %s latency: got %0d want 34", name, cyc); end
        n_checks++;
        if (bus.hi !== exp_hi || bus.lo !== exp_lo || bus.div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL %s result: hi=%h lo=%h dz=%b want hi=%h lo=%h dz=0", name, bus.hi, bus.lo, bus.div_zero, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'h0; bus.b = 32'h0;
        bus.flush = 1'b0; bus.hilo_we = 2'b00;
        #23;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div_zero !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h want all 0", bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_mult;
        int cyc;
        int bc;
        do_start(2'b00, 32'hFFFF_FFFF, 32'h2);
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mult busy_after_start: got %b want 1", bus.busy); end
        wait_done(cyc, bc);
        n_checks++;
        if (cyc !== 34) begin n_fail++; $display("FAIL mult latency: got %0d want 34", cyc); end
        n_checks++;
        if (bc !== 33 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mult busy_cycles: got %0d busy=%b want 33 busy=0", bc, bus.busy); end
        n_checks++;
        if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFE) begin
            n_fail++; $display("FAIL mult result: hi=%h lo=%h want ffffffff fffffffe", bus.hi, bus.lo);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mult done_pulse: got %b want 0", bus.done); end
        run_op("multu",     2'b01, 32'hFFFF_FFFF, 32'h2,          32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'h5,          32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult_nn",   2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB,  32'h0,         32'd15);
    endtask

    task automatic test_div;
        run_op("div_m7_2",  2'b10, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2",  2'b10, 32'h7,         32'hFFFF_FFFE,  32'h1,         32'hFFFF_FFFD);
        run_op("divu",      2'b11, 32'd100,       32'd7,          32'd2,         32'd14);
        run_op("div_min",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         32'h8000_0000);
    endtask

    task automatic test_div_zero_back_to_back;
        int cyc;
        int bc;
        @(negedge clk);
        bus.a = 32'h11; bus.hilo_we = 2'b10;
        @(negedge clk);
        bus.a = 32'h22; bus.hilo_we = 2'b01;
        @(negedge clk);
        bus.hilo_we = 2'b00;
        n_checks++;
        if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
            n_fail++; $display("FAIL mthi_mtlo: hi=%h lo=%h want 11 22", bus.hi, bus.lo);
        end
        do_start(2'b11, 32'd50, 32'd0);
        wait_done(cyc, bc);
        n_checks++;
        if (cyc !== 2 || bus.div_zero !== 1'b1) begin
            n_fail++; $display("FAIL divzero: latency=%0d dz=%b want 2 1", cyc, bus.div_zero);
        end
        n_checks++;
        if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin
            n_fail++; $display("FAIL divzero_hold: hi=%h lo=%h want 11 22", bus.hi, bus.lo);
        end
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.div_zero !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept: busy=%b dz=%b want 1 0", bus.busy, bus.div_zero);
        end
        wait_done(cyc, bc);
        n_checks++;
        if (cyc !== 34 || bus.hi !== 32'd2 || bus.lo !== 32'd14) begin
            n_fail++; $display("FAIL b2b_result: lat=%0d hi=%h lo=%h want 34 2 e", cyc, bus.hi, bus.lo);
        end
    endtask

    task automatic test_busy_ignore;
        int cyc;
        int bc;
        do_start(2'b01, 32'd3, 32'd4);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'hDEAD; bus.b = 32'h1; bus.hilo_we = 2'b11;
        @(negedge clk);
        bus.start = 1'b0; bus.hilo_we = 2'b00;
        wait_done(cyc, bc);
        n_checks++;
        if (cyc + 1 !== 34 || bus.hi !== 32'h0 || bus.lo !== 32'd12) begin
            n_fail++; $display("FAIL busy_ignore: lat=%0d hi=%h lo=%h want 34 0 c", cyc + 1, bus.hi, bus.lo);
        end
    endtask

    task automatic test_flush;
        int cyc;
        int bc;
        do_start(2'b00, 32'd5, 32'd5);
        repeat (12) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        wait_done(cyc, bc);
        n_checks++;
        if (cyc !== 0 || bus.hi !== 32'h0 || bus.lo !== 32'd12) begin
            n_fail++; $display("FAIL flush_nodone: done_at=%0d hi=%h lo=%h want 0 0 c", cyc, bus.hi, bus.lo);
        end
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_start: busy=%b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        int bc;
        do_start(2'b01, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h want 0 0 0", bus.busy, bus.hi, bus.lo);
        end
        @(negedge clk);
        rst = 1'b1;
        wait_done(cyc, bc);
        n_checks++;
        if (cyc !== 0) begin n_fail++; $display("FAIL reset_mid_nodone: done_at=%0d want 0", cyc); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset;
        test_mult;
        test_div;
        test_div_zero_back_to_back;
        test_busy_ignore;
        test_flush;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
